// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes and decode constants
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'h0,
    ALU_OR      = 4'h1,
    ALU_ADD     = 4'h2,
    ALU_SUB     = 4'h3,
    ALU_XOR     = 4'h4,
    ALU_SLL     = 4'h5,
    ALU_SRL     = 4'h6,
    ALU_SRA     = 4'h7,
    ALU_EQ      = 4'h8,
    ALU_ILLEGAL = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUOP_LDST   = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// rtl/alu_issue_skid.sv - 2-entry skid buffer (output entry + skid entry) with registered in_ready
module alu_issue_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, drain;

  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain || !out_valid_q) begin
      // Output slot frees this edge; the skid entry is older than any new op.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = in_data;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - ALUOp/Funct decode and operand select feeding the ALU through a skid buffer
// Optional issue/illegal counters when ALU_ISSUE_STATS_EN is defined.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
`ifdef ALU_ISSUE_STATS_EN
  output logic [31:0]              issue_count,
  output logic [31:0]              illegal_count,
`endif
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               ALUOp,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  input  logic                     ALUSrc,
  input  logic [DATA_WIDTH-1:0]    RD1,
  input  logic [DATA_WIDTH-1:0]    RD2,
  input  logic [DATA_WIDTH-1:0]    Imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     illegal
);

  localparam int SHAMT_W   = $clog2(DATA_WIDTH);
  localparam int PAYLOAD_W = OPCODE_LENGTH + 2 * DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] SHAMT_MASK =
    {{(DATA_WIDTH - SHAMT_W){1'b0}}, {SHAMT_W{1'b1}}};

  alu_op_e               op;
  logic                  is_r;
  logic [DATA_WIDTH-1:0] src_b_sel;
  logic [DATA_WIDTH-1:0] src_b;
  logic [PAYLOAD_W-1:0]  in_payload, out_payload;

  always_comb begin
    op   = ALU_ILLEGAL;
    is_r = (ALUOp == ALUOP_RTYPE);
    case (ALUOp)
      ALUOP_LDST:   op = ALU_ADD;
      ALUOP_BRANCH: if (Funct3 == 3'b000 || Funct3 == 3'b001) op = ALU_EQ;
      default: begin
        // I-type ignores Funct7 except where it selects the shift flavour.
        case (Funct3)
          3'b000: begin
            if (!is_r || Funct7 == F7_BASE) op = ALU_ADD;
            else if (Funct7 == F7_ALT)      op = ALU_SUB;
          end
          3'b111: if (!is_r || Funct7 == F7_BASE) op = ALU_AND;
          3'b110: if (!is_r || Funct7 == F7_BASE) op = ALU_OR;
          3'b100: if (!is_r || Funct7 == F7_BASE) op = ALU_XOR;
          3'b001: if (Funct7 == F7_BASE) op = ALU_SLL;
          3'b101: begin
            if (Funct7 == F7_BASE)     op = ALU_SRL;
            else if (Funct7 == F7_ALT) op = ALU_SRA;
          end
          default: op = ALU_ILLEGAL;
        endcase
      end
    endcase
  end

  assign src_b_sel = ALUSrc ? Imm : RD2;
  assign src_b     = is_shift(op) ? (src_b_sel & SHAMT_MASK) : src_b_sel;

  assign in_payload = {OPCODE_LENGTH'(op), RD1, src_b, (op == ALU_ILLEGAL)};

  alu_issue_skid #(
    .WIDTH(PAYLOAD_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_payload),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_payload)
  );

  assign {Operation, SrcA, SrcB, illegal} = out_payload;

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issue_count_q, issue_count_d;
  logic [31:0] illegal_count_q, illegal_count_d;
  logic        drain;

  assign drain = out_valid && out_ready;

  always_comb begin
    issue_count_d   = issue_count_q;
    illegal_count_d = illegal_count_q;
    if (drain && issue_count_q != '1) issue_count_d = issue_count_q + 32'd1;
    if (drain && illegal && illegal_count_q != '1) illegal_count_d = illegal_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_count_q   <= '0;
      illegal_count_q <= '0;
    end else begin
      issue_count_q   <= issue_count_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign issue_count   = issue_count_q;
  assign illegal_count = illegal_count_q;
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// tb/tb_alu_op_issue.sv - directed table-driven bench for alu_op_issue
module tb_alu_op_issue;

  logic        clk, reset, flush, in_valid, in_ready, ALUSrc, out_valid, out_ready, illegal;
  logic [1:0]  ALUOp;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [31:0] RD1, RD2, Imm, SrcA, SrcB;
  logic [3:0]  Operation;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issue_count, illegal_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk          (clk),
`ifdef ALU_ISSUE_STATS_EN
    .issue_count  (issue_count),
    .illegal_count(illegal_count),
`endif
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ALUOp        (ALUOp),
    .Funct3       (Funct3),
    .Funct7       (Funct7),
    .ALUSrc       (ALUSrc),
    .RD1          (RD1),
    .RD2          (RD2),
    .Imm          (Imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .Operation    (Operation),
    .SrcA         (SrcA),
    .SrcB         (SrcB),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        alusrc;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [3:0]  exp_op;
    logic [31:0] exp_srcb;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7,
                              input logic s, input logic [31:0] rd2, input logic [31:0] imm,
                              input logic [3:0] eop, input logic [31:0] esb, input logic eill);
    vec_t v;
    v.aluop = a; v.f3 = f3; v.f7 = f7; v.alusrc = s; v.rd2 = rd2; v.imm = imm;
    v.exp_op = eop; v.exp_srcb = esb; v.exp_ill = eill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_op(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7,
                        input logic s, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm);
    ALUOp = a; Funct3 = f3; Funct7 = f7; ALUSrc = s; RD1 = rd1; RD2 = rd2; Imm = imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(2'b10, 3'b000, 7'h20, 0, 32'd3,        32'd0,        4'h3, 32'd3,        0);
    vecs[1]  = mk(2'b10, 3'b000, 7'h00, 0, 32'd3,        32'd0,        4'h2, 32'd3,        0);
    vecs[2]  = mk(2'b10, 3'b111, 7'h00, 0, 32'hF0F0,     32'd0,        4'h0, 32'hF0F0,     0);
    vecs[3]  = mk(2'b10, 3'b110, 7'h01, 0, 32'd3,        32'd0,        4'hF, 32'd3,        1);
    vecs[4]  = mk(2'b10, 3'b100, 7'h00, 0, 32'd3,        32'd0,        4'h4, 32'd3,        0);
    vecs[5]  = mk(2'b10, 3'b001, 7'h00, 0, 32'h123,      32'd0,        4'h5, 32'h3,        0);
    vecs[6]  = mk(2'b10, 3'b101, 7'h20, 0, 32'hFFFFFFE7, 32'd0,        4'h7, 32'h7,        0);
    vecs[7]  = mk(2'b10, 3'b010, 7'h00, 0, 32'd3,        32'd0,        4'hF, 32'd3,        1);
    vecs[8]  = mk(2'b11, 3'b101, 7'h20, 1, 32'd9,        32'hFFFFFC23, 4'h7, 32'h3,        0);
    vecs[9]  = mk(2'b11, 3'b111, 7'h7F, 1, 32'd9,        32'hFFFFF800, 4'h0, 32'hFFFFF800, 0);
    vecs[10] = mk(2'b11, 3'b011, 7'h00, 1, 32'd9,        32'h55,       4'hF, 32'h55,       1);
    vecs[11] = mk(2'b11, 3'b001, 7'h01, 1, 32'd9,        32'h7,        4'hF, 32'h7,        1);
    vecs[12] = mk(2'b01, 3'b000, 7'h00, 0, 32'd3,        32'd0,        4'h8, 32'd3,        0);
    vecs[13] = mk(2'b01, 3'b001, 7'h00, 0, 32'd3,        32'd0,        4'h8, 32'd3,        0);
    vecs[14] = mk(2'b01, 3'b100, 7'h00, 0, 32'd3,        32'd0,        4'hF, 32'd3,        1);
    vecs[15] = mk(2'b00, 3'b010, 7'h00, 1, 32'd3,        32'h10,       4'h2, 32'h10,       0);
    vecs[16] = mk(2'b10, 3'b101, 7'h00, 0, 32'h3F,       32'd0,        4'h6, 32'h1F,       0);
    vecs[17] = mk(2'b10, 3'b001, 7'h20, 0, 32'd3,        32'd0,        4'hF, 32'd3,        1);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_op(2'b00, 3'b000, 7'h00, 1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    tick();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_operation", Operation, 0);
    chk("reset_srca", SrcA, 0);
    chk("reset_srcb", SrcB, 0);
    chk("reset_illegal", illegal, 0);
    reset = 1'b0;
    tick();

    // Decode table, one op per cycle with out_ready high (accept replaces draining entry).
    for (int i = 0; i < 18; i++) begin
      set_op(vecs[i].aluop, vecs[i].f3, vecs[i].f7, vecs[i].alusrc, 32'd10 + i, vecs[i].rd2,
             vecs[i].imm);
      in_valid = 1'b1;
      tick();
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_operation", i), Operation, vecs[i].exp_op);
      chk($sformatf("vec%0d_srca", i), SrcA, 32'd10 + i);
      chk($sformatf("vec%0d_srcb", i), SrcB, vecs[i].exp_srcb);
      chk($sformatf("vec%0d_illegal", i), illegal, vecs[i].exp_ill);
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_idle_out_valid", out_valid, 0);

    // Stall: three back-to-back ops with out_ready low.
    out_ready = 1'b0;
    set_op(2'b00, 3'b000, 7'h00, 1'b0, 32'd1, 32'd0, 32'd0);
    in_valid = 1'b1;
    tick();
    chk("stall_a_srca", SrcA, 1);
    chk("stall_a_in_ready", in_ready, 1);
    RD1 = 32'd2;
    tick();
    chk("stall_b_in_ready", in_ready, 0);
    chk("stall_b_hold_srca", SrcA, 1);
    RD1 = 32'd3;
    tick();
    chk("stall_c_in_ready", in_ready, 0);
    chk("stall_c_hold_srca", SrcA, 1);
    chk("stall_c_out_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("release_1_srca", SrcA, 2);
    chk("release_1_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("release_2_srca", SrcA, 3);
    chk("release_2_out_valid", out_valid, 1);
    tick();
    chk("release_3_out_valid", out_valid, 0);

    // Flush with both entries full and a new op offered.
    out_ready = 1'b0;
    RD1 = 32'd20; in_valid = 1'b1;
    tick();
    RD1 = 32'd21;
    tick();
    chk("preflush_in_ready", in_ready, 0);
    RD1 = 32'd22; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    chk("postflush_out_valid", out_valid, 0);

    // Asynchronous reset pulsed mid-stall.
    out_ready = 1'b0;
    RD1 = 32'd30; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("prereset_out_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_out_valid", out_valid, 0);
    chk("async_reset_in_ready", in_ready, 1);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("after_reset_out_valid", out_valid, 0);

`ifdef ALU_ISSUE_STATS_EN
    chk("stats_reset_issue", issue_count, 0);
    chk("stats_reset_illegal", illegal_count, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) set_op(2'b10, 3'b010, 7'h00, 1'b0, 32'd40 + i, 32'd1, 32'd0);
      else        set_op(2'b00, 3'b000, 7'h00, 1'b0, 32'd40 + i, 32'd1, 32'd0);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("stats_issue_count", issue_count, 5);
    chk("stats_illegal_count", illegal_count, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
